// File: rtl/c_rotate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : c_rotate_pipe
// Description : Pipelined, flow-controlled element rotator built as a log2
//               barrel network. Each level can optionally be followed by a
//               register stage (stage_regs bitmask). Rotation direction is
//               chosen per transfer. The amount comes from in_amount or from
//               an internal round-robin pointer. Valid/ready on both sides.
//               Optional feature macro: C_ROTATE_PIPE_RANGE_CHECK_EN
//               (enables the sticky err_range out-of-range flag).
// Revision    : 1.0 - initial release
// ============================================================================
module c_rotate_pipe #(
    parameter int num_elems  = 8,
    parameter int elem_width = 1,
    localparam int amount_width = $clog2(num_elems),
    parameter logic [amount_width-1:0] stage_regs = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [num_elems*elem_width-1:0]  in_data,
    input  logic [amount_width-1:0]          in_amount,
    input  logic                             in_dir,
    input  logic                             in_use_ptr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [num_elems*elem_width-1:0]  out_data,
    output logic [amount_width-1:0]          ptr,
    output logic                             err_range
);

    localparam int c_dw = num_elems * elem_width;

    // num_elems widened by one bit so it can be compared against an amount
    // even when num_elems is a power of two and does not fit amount_width.
    localparam logic [amount_width:0]   c_n_ext   = (amount_width + 1)'(num_elems);
    localparam logic [amount_width-1:0] c_n_trunc = amount_width'(num_elems);
    localparam logic [amount_width-1:0] c_last    = amount_width'(num_elems - 1);

    // Per-level handshake/data buses. Index 0 is the input side, index
    // amount_width is the output side; level i sits between i and i+1.
    logic                    w_lv_valid [0:amount_width];
    logic                    w_lv_ready [0:amount_width];
    logic [c_dw-1:0]         w_lv_data  [0:amount_width];
    logic [amount_width-1:0] w_lv_amt   [0:amount_width];
    logic                    w_lv_dir   [0:amount_width];

    logic [amount_width-1:0] r_ptr;
    logic [amount_width-1:0] w_amt_sel;
    logic [amount_width-1:0] w_k;
    logic                    w_accept;

    // ------------------------------------------------------------------
    // Amount selection and reduction into [0, num_elems-1]. Since the
    // selected amount is always below 2*num_elems, one subtract suffices.
    // ------------------------------------------------------------------
    assign w_amt_sel = in_use_ptr ? r_ptr : in_amount;
    assign w_k       = ({1'b0, w_amt_sel} >= c_n_ext) ? (w_amt_sel - c_n_trunc)
                                                       : w_amt_sel;

    assign w_accept  = in_valid && w_lv_ready[0];

    // Input side of the network
    assign w_lv_valid[0] = in_valid;
    assign w_lv_data[0]  = in_data;
    assign w_lv_amt[0]   = w_k;
    assign w_lv_dir[0]   = in_dir;
    assign in_ready      = w_lv_ready[0];

    // Output side of the network
    assign w_lv_ready[amount_width] = out_ready;
    assign out_valid = w_lv_valid[amount_width];
    assign out_data  = w_lv_data[amount_width];

    // ------------------------------------------------------------------
    // Barrel levels. Level i rotates by (2^i mod num_elems) when bit i of
    // the carried amount is set; the amount and direction ride along with
    // the data so every stage sees the control of its own transfer.
    // ------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < amount_width; gi++) begin : g_level
            localparam int c_shift = (1 << gi) % num_elems;

            logic [c_dw-1:0] w_rot;

            for (gj = 0; gj < num_elems; gj++) begin : g_elem
                localparam int c_src_l = (gj + c_shift) % num_elems;
                localparam int c_src_r = (gj + num_elems - c_shift) % num_elems;

                assign w_rot[gj*elem_width +: elem_width] =
                    !w_lv_amt[gi][gi] ? w_lv_data[gi][gj*elem_width      +: elem_width] :
                    w_lv_dir[gi]      ? w_lv_data[gi][c_src_r*elem_width +: elem_width] :
                                        w_lv_data[gi][c_src_l*elem_width +: elem_width];
            end

            if (stage_regs[gi]) begin : g_reg
                logic                    r_valid;
                logic [c_dw-1:0]         r_data;
                logic [amount_width-1:0] r_amt;
                logic                    r_dir;

                // A stage may load when it is empty or its content leaves
                assign w_lv_ready[gi] = !r_valid || w_lv_ready[gi+1];

                // Stage occupancy; cleared by reset so in-flight data is dropped
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_valid <= 1'b0;
                    end else if (w_lv_ready[gi]) begin
                        r_valid <= w_lv_valid[gi];
                    end
                end

                // Payload capture; contents are don't-care while the stage is empty
                always_ff @(posedge clk) begin
                    if (w_lv_ready[gi] && w_lv_valid[gi]) begin
                        r_data <= w_rot;
                        r_amt  <= w_lv_amt[gi];
                        r_dir  <= w_lv_dir[gi];
                    end
                end

                assign w_lv_valid[gi+1] = r_valid;
                assign w_lv_data[gi+1]  = r_data;
                assign w_lv_amt[gi+1]   = r_amt;
                assign w_lv_dir[gi+1]   = r_dir;
            end else begin : g_comb
                assign w_lv_ready[gi]   = w_lv_ready[gi+1];
                assign w_lv_valid[gi+1] = w_lv_valid[gi];
                assign w_lv_data[gi+1]  = w_rot;
                assign w_lv_amt[gi+1]   = w_lv_amt[gi];
                assign w_lv_dir[gi+1]   = w_lv_dir[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pointer: advances only on transfers that consumed it,
    // so the amount used is always the pre-increment value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_accept && in_use_ptr) begin
            r_ptr <= (r_ptr == c_last) ? '0 : (r_ptr + 1'b1);
        end
    end

    assign ptr = r_ptr;

    // ------------------------------------------------------------------
    // Out-of-range reporting. The data path always uses the reduced
    // amount; this flag only records that an explicit amount overflowed.
    // ------------------------------------------------------------------
`ifdef C_ROTATE_PIPE_RANGE_CHECK_EN
    logic r_err_range;

    // Sticky flag set by any accepted explicit amount >= num_elems
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_range <= 1'b0;
        end else if (w_accept && !in_use_ptr && ({1'b0, in_amount} >= c_n_ext)) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c_rotate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_c_rotate_pipe
// Description : Directed self-checking bench for c_rotate_pipe. Three
//               instances: 8x4 combinational, 8x4 with stage_regs=3'b101,
//               and 6x4 combinational for amount reduction / range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c_rotate_pipe;

`ifdef C_ROTATE_PIPE_RANGE_CHECK_EN
    localparam logic c_err_on = 1'b1;
`else
    localparam logic c_err_on = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] d8;
    logic [2:0]  amt8;
    logic        dir;
    logic        use_ptr;

    logic        a_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
    logic [31:0] a_out_data;
    logic [2:0]  a_ptr;

    logic        b_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [31:0] b_out_data;
    logic [2:0]  b_ptr;

    logic        c_valid, c_in_ready, c_out_valid, c_out_ready, c_err, c_use_ptr;
    logic [23:0] c_data, c_out_data;
    logic [2:0]  c_amt, c_ptr;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_arr [0:15];
    int          vcnt;

    c_rotate_pipe #(.num_elems(8), .elem_width(4), .stage_regs(3'b000)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_valid), .in_ready(a_in_ready), .in_data(d8),
        .in_amount(amt8), .in_dir(dir), .in_use_ptr(use_ptr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .ptr(a_ptr), .err_range(a_err)
    );

    c_rotate_pipe #(.num_elems(8), .elem_width(4), .stage_regs(3'b101)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_valid), .in_ready(b_in_ready), .in_data(d8),
        .in_amount(amt8), .in_dir(dir), .in_use_ptr(use_ptr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .ptr(b_ptr), .err_range(b_err)
    );

    c_rotate_pipe #(.num_elems(6), .elem_width(4), .stage_regs(3'b000)) u_c (
        .clk(clk), .reset_n(reset_n),
        .in_valid(c_valid), .in_ready(c_in_ready), .in_data(c_data),
        .in_amount(c_amt), .in_dir(dir), .in_use_ptr(c_use_ptr),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .ptr(c_ptr), .err_range(c_err)
    );

    // Reference rotation of eight 4-bit elements, element 0 in bits [3:0]
    function automatic logic [31:0] rot8(input logic [31:0] d, input int k, input logic rdir);
        logic [31:0] r;
        int          src;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            src = rdir ? ((j - k + 8) % 8) : ((j + k) % 8);
            r[j*4 +: 4] = d[src*4 +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        d8 = '0; amt8 = '0; dir = 1'b0; use_ptr = 1'b0;
        a_valid = 1'b0; a_out_ready = 1'b1;
        b_valid = 1'b0; b_out_ready = 1'b1;
        c_valid = 1'b0; c_out_ready = 1'b1; c_data = '0; c_amt = '0; c_use_ptr = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_b_ptr",       32'(b_ptr),       32'd0);
        chk("rst_c_err",       32'(c_err),       32'd0);
        a_out_ready = 1'b0;
        #1;
        chk("rst_a_in_ready_follow", 32'(a_in_ready), 32'd0);
        a_out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- combinational rotation (L=0) ----------------
        @(negedge clk);
        d8 = 32'h7654_3210; amt8 = 3'd3; dir = 1'b0; a_valid = 1'b1;
        #1;
        chk("a_valid_same_cycle", 32'(a_out_valid), 32'd1);
        chk("a_left3",  a_out_data, 32'h2107_6543);
        amt8 = 3'd7;
        #1;
        chk("a_left7",  a_out_data, 32'h6543_2107);
        amt8 = 3'd0;
        #1;
        chk("a_left0",  a_out_data, 32'h7654_3210);
        amt8 = 3'd3; dir = 1'b1;
        #1;
        chk("a_right3", a_out_data, 32'h4321_0765);
        a_out_ready = 1'b0;
        #1;
        chk("a_in_ready_follows", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        a_valid = 1'b0; a_out_ready = 1'b1;
        #1;
        chk("a_idle_valid", 32'(a_out_valid), 32'd0);
        chk("a_ptr_unchanged", 32'(a_ptr), 32'd0);

        // ---------------- L=2 single transfer ----------------
        @(negedge clk);
        d8 = 32'h7654_3210; amt8 = 3'd3; dir = 1'b1; b_valid = 1'b1;
        #1;
        chk("b_in_ready", 32'(b_in_ready), 32'd1);
        chk("b_valid_c0", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("b_valid_c1", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("b_valid_c2", 32'(b_out_valid), 32'd1);
        chk("b_right3",   b_out_data, 32'h4321_0765);
        @(negedge clk);
        #1;
        chk("b_valid_c3", 32'(b_out_valid), 32'd0);

        // ---------------- L=2 back-to-back 10 transfers ----------------
        vcnt = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            #1;
            if (b_out_valid) vcnt++;
            chk("b2b_valid", 32'(b_out_valid), ((c >= 2) && (c < 12)) ? 32'd1 : 32'd0);
            if ((c >= 2) && (c < 12)) chk("b2b_data", b_out_data, exp_arr[c-2]);
            chk("b2b_in_ready", 32'(b_in_ready), 32'd1);
            b_valid = (c < 10);
            d8      = 32'h7654_3210 + 32'h1111_1111 * 32'(c);
            amt8    = 3'(c % 8);
            dir     = c[0];
            exp_arr[c] = rot8(d8, c % 8, dir);
        end
        chk("b2b_count", 32'(vcnt), 32'd10);

        // ---------------- stall with out_ready low ----------------
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b_out_ready = 1'b0;
            b_valid = 1'b1; dir = 1'b0;
            if (c == 0) begin d8 = 32'h7654_3210; amt8 = 3'd1; end
            else if (c == 1) begin d8 = 32'hFEDC_BA98; amt8 = 3'd2; end
            else begin d8 = 32'h1111_1111; amt8 = 3'd4; end
            #1;
            chk("stall_in_ready", 32'(b_in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk("stall_valid", 32'(b_out_valid), 32'd1);
                chk("stall_data",  b_out_data, 32'h0765_4321);
            end
        end
        @(negedge clk);
        b_valid = 1'b0; b_out_ready = 1'b1;
        #1;
        chk("drain0_valid", 32'(b_out_valid), 32'd1);
        chk("drain0_data",  b_out_data, 32'h0765_4321);
        @(negedge clk);
        #1;
        chk("drain1_valid", 32'(b_out_valid), 32'd1);
        chk("drain1_data",  b_out_data, 32'h98FE_DCBA);
        @(negedge clk);
        #1;
        chk("drain_empty",  32'(b_out_valid), 32'd0);

        // ---------------- pointer-driven amounts ----------------
        chk("ptr_start", 32'(b_ptr), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            chk("ptr_value", 32'(b_ptr), 32'(((c < 10) ? c : 10) % 8));
            if (c >= 2) chk("ptr_data", b_out_data, rot8(32'h7654_3210, (c - 2) % 8, 1'b0));
            b_valid = (c < 10); use_ptr = 1'b1;
            d8 = 32'h7654_3210; dir = 1'b0; amt8 = 3'd5;
        end
        chk("ptr_after10", 32'(b_ptr), 32'd2);
        @(negedge clk);
        b_valid = 1'b1; use_ptr = 1'b0; amt8 = 3'd5; dir = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("ptr_hold", 32'(b_ptr), 32'd2);
        @(negedge clk);
        #1;
        chk("explicit_left5", b_out_data, 32'h4321_0765);

        // ---------------- non-power-of-two reduction and range flag ----------------
        @(negedge clk);
        c_data = 24'h54_3210; c_amt = 3'd7; dir = 1'b0; c_valid = 1'b1;
        #1;
        chk("c_err_before", 32'(c_err), 32'd0);
        chk("c_valid",      32'(c_out_valid), 32'd1);
        chk("c_left7",      32'(c_out_data), 32'h05_4321);
        @(negedge clk);
        c_amt = 3'd2; dir = 1'b1;
        #1;
        chk("c_err_set",    32'(c_err), 32'(c_err_on));
        chk("c_right2",     32'(c_out_data), 32'h32_1054);
        @(negedge clk);
        c_amt = 3'd6;
        #1;
        chk("c_right6",     32'(c_out_data), 32'h54_3210);
        c_amt = 3'd7;
        #1;
        chk("c_right7",     32'(c_out_data), 32'h43_2105);
        @(negedge clk);
        c_valid = 1'b0;
        #1;
        chk("c_err_sticky", 32'(c_err), 32'(c_err_on));
        chk("c_ptr",        32'(c_ptr), 32'd0);

        // ---------------- reset with items in flight ----------------
        @(negedge clk);
        b_out_ready = 1'b0; use_ptr = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        chk("inflight_valid", 32'(b_out_valid), 32'd1);
        chk("inflight_ptr",   32'(b_ptr), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(b_out_valid), 32'd0);
        chk("async_rst_ptr",   32'(b_ptr), 32'd0);
        chk("async_rst_ready", 32'(b_in_ready), 32'd1);
        chk("async_rst_err",   32'(c_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; b_out_ready = 1'b1; use_ptr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("no_stale", 32'(b_out_valid), 32'd0);
        end
        chk("post_rst_ptr", 32'(b_ptr), 32'd0);
        chk("post_rst_err", 32'(c_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
